sram_bist: RTL and testbench
============================

# sram_bist

March C- built-in self-test controller for the SRAMC memory array. It sits directly downstream of the AHB slave interface and upstream of the SRAM core's eight 8K×8 macros (bank0 = q0..q3, bank1 = q4..q7). In functional mode it forwards the interface's SRAM controls unchanged. During a test it takes ownership of the array, runs March C- across all eight byte lanes in parallel, and reports pass/fail plus the first failing location.

## Interface
Parameters:
- ADDR_W, 13, SRAM word-address width; depth N = 2^ADDR_W.

Ports:
- hclk  in  1  clock
- hresetn  in  1  reset; asynchronous, active-low
- bist_start  in  1  level/pulse; sampled only in IDLE
- func_sram_w_en  in  1  functional write enable, 0 = write
- func_bank0_csn, func_bank1_csn  in  4 each  functional chip selects, active-low
- func_sram_addr  in  ADDR_W  functional word address
- func_sram_wdata  in  32  functional write data
- sram_q0..sram_q7  in  8 each  SRAM read data; valid one cycle after the read address
- sram_w_en, bank0_csn, bank1_csn, sram_addr, sram_wdata  out  as func_*  muxed SRAM controls
- bist_busy  out  1  BIST owns the array
- bist_done  out  1  sticky; test completed
- bist_fail  out  1  sticky; at least one mismatch
- fail_addr  out  ADDR_W  address of the first mismatch
- fail_elem  out  3  March element (1..5) of the first mismatch
- fail_lanes  out  8  byte lanes miscomparing at the first mismatch; bit i = sram_q i

## Operation
- States: IDLE, M0..M5, DRAIN.
- Transitions:
  - IDLE→M0 when bist_start=1.
  - Mk→Mk+1 after the last address of element k.
  - M5→DRAIN→IDLE.
- Elements, with D0=32'h0000_0000 and D1=32'hFFFF_FFFF:
  - M0 ⇑ w0
  - M1 ⇑ (r0, w1)
  - M2 ⇑ (r1, w0)
  - M3 ⇓ (r0, w1)
  - M4 ⇓ (r1, w0)
  - M5 ⇑ r0
- ⇑ runs address 0→N-1; ⇓ runs N-1→0. Address wrap ends the element.
- Op sequencing: r/w elements take 2 cycles per address (read, then write to the same address). M0 and M5 take 1 cycle per address.
- Drive while busy:
  - bank0_csn = bank1_csn = 4'b0000.
  - sram_w_en = 0 on write cycles, 1 on read cycles.
  - sram_wdata = the D pattern.
- Compare: each read registers {element, address, expected}; the next cycle compares the 64-bit {q7..q0} against the expected pattern replicated ×2.
- Failure capture:
  - On the first mismatch, capture fail_addr, fail_elem and fail_lanes, and set bist_fail.
  - Later mismatches do not overwrite the capture.
  - The test always runs to completion.
- Mux: bist_busy=0 (IDLE) → all outputs equal their func_* inputs combinationally. bist_busy=1 → BIST drives them and func_* inputs are ignored.
- bist_busy=1 in M0..M5 and DRAIN.
- bist_start while busy is ignored.
- bist_start accepted in IDLE clears bist_done, bist_fail, fail_addr, fail_elem and fail_lanes.
- bist_done sets at the DRAIN→IDLE edge and holds until the next accepted start.
- Reset (also mid-test):
  - State returns to IDLE and all status outputs go to 0.
  - The mux returns to functional immediately.
  - Array contents are undefined.

## Timing
- Start accepted at edge E0; the first write occurs in the cycle after E0.
- Op cycles total 10·N. The final read compares in DRAIN.
- bist_done=1 after edge E0+10·N+1; bist_busy falls on that same edge.
- Read latency is one cycle. The compare is pipelined one stage, so write-after-read to the same address does not disturb the registered check.
- fail_* outputs become valid at the edge that registers the comparison (read cycle + 2 edges).
- Reset values: bist_busy, bist_done, bist_fail = 0; fail_addr, fail_elem, fail_lanes = 0; muxed outputs = func_* inputs.

## Structure
- Package sram_bist_pkg holds:
  - state enum
  - element count (6)
  - D0/D1 constants
  - read/write op encoding
- Sub-module sram_bist_cmp: a one-stage registered comparator. Inputs are the 8 q bytes, an expected byte and a compare-valid flag; output is the 8-bit lane mismatch vector.
- Top level holds the FSM, the up/down address counter, the phase bit, the output mux and the capture registers.

## Test plan
- ADDR_W=3, fault-free behavioural SRAM, start pulse → bist_busy for 81 cycles; bist_done=1 at E0+81; bist_fail=0.
- sram_q6 bit5 stuck-at-1 at address 3 → bist_fail=1, fail_addr=3, fail_elem=1, fail_lanes=8'h40; run still completes at E0+81.
- bank1 address 5 lane q4 stuck-at-0 → first fail at M2 ⇑ r1: fail_addr=5, fail_elem=2, fail_lanes=8'h10.
- bist_start re-pulsed at cycle 30 of a run → ignored; done still at E0+81.
- hresetn low at cycle 20 → bist_busy=0 and outputs track func_* the same cycle; status is 0; a rerun passes.
- Idle passthrough: func_addr=13'h1A5, csn 4'b1100/4'b1111, w_en=0, wdata=32'hDEADBEEF → identical outputs; next start clears the previous fail status.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM March C- self-test controller.
// Element ordering and data-background helpers live here so the FSM reads cleanly.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_M0    = 3'd1,
        ST_M1    = 3'd2,
        ST_M2    = 3'd3,
        ST_M3    = 3'd4,
        ST_M4    = 3'd5,
        ST_M5    = 3'd6,
        ST_DRAIN = 3'd7
    } state_e;

    localparam int NUM_ELEM = 6;

    localparam logic [31:0] D0 = 32'h0000_0000;
    localparam logic [31:0] D1 = 32'hFFFF_FFFF;

    // Encoded to match the SRAM's active-low write enable.
    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

    function automatic logic [2:0] elem_num(input state_e s);
        case (s)
            ST_M1:   return 3'd1;
            ST_M2:   return 3'd2;
            ST_M3:   return 3'd3;
            ST_M4:   return 3'd4;
            ST_M5:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic is_rw(input state_e s);
        return s inside {ST_M1, ST_M2, ST_M3, ST_M4};
    endfunction

    function automatic logic is_down(input state_e s);
        return s inside {ST_M3, ST_M4};
    endfunction

    // Background expected on the read half of an element (1 = D1).
    function automatic logic read_fill(input state_e s);
        return s inside {ST_M2, ST_M4};
    endfunction

    // Background written by an element (1 = D1).
    function automatic logic write_fill(input state_e s);
        return s inside {ST_M1, ST_M3};
    endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// One-stage read-data comparator: latches the expected byte alongside the read,
// then flags each byte lane of the returning data that differs from it.
module sram_bist_cmp (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [63:0] q,
    input  logic [7:0]  expected,
    input  logic        cmp_valid,
    output logic [7:0]  mismatch
);

    logic [7:0] exp_q;
    logic       valid_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            exp_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            exp_q   <= expected;
            valid_q <= cmp_valid;
        end
    end

    always_comb begin
        mismatch = '0;
        for (int i = 0; i < 8; i++) begin
            mismatch[i] = valid_q && (q[8*i +: 8] != exp_q);
        end
    end

endmodule

// File: rtl/sram_bist.sv
// March C- BIST controller for the eight-lane SRAM array; passes functional
// controls through when idle and records the first failing location.
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              bist_start,
    input  logic              func_sram_w_en,
    input  logic [3:0]        func_bank0_csn,
    input  logic [3:0]        func_bank1_csn,
    input  logic [ADDR_W-1:0] func_sram_addr,
    input  logic [31:0]       func_sram_wdata,
    input  logic [7:0]        sram_q0,
    input  logic [7:0]        sram_q1,
    input  logic [7:0]        sram_q2,
    input  logic [7:0]        sram_q3,
    input  logic [7:0]        sram_q4,
    input  logic [7:0]        sram_q5,
    input  logic [7:0]        sram_q6,
    input  logic [7:0]        sram_q7,
    output logic              sram_w_en,
    output logic [3:0]        bank0_csn,
    output logic [3:0]        bank1_csn,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [7:0]        fail_lanes
);

    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

    state_e            state;
    state_e            next_elem;
    logic [ADDR_W-1:0] addr;
    logic              phase;
    logic              busy_q;
    op_e               op;
    logic              fill;
    logic              rd_issue;
    logic              step_done;
    logic              last_addr;
    logic [31:0]       bist_wdata;
    logic [2:0]        rd_elem;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        mismatch;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        op = OP_READ;
        if (state == ST_M0 || (is_rw(state) && phase)) begin
            op = OP_WRITE;
        end
    end

    assign fill       = (op == OP_READ) ? read_fill(state) : write_fill(state);
    assign bist_wdata = fill ? D1 : D0;
    assign rd_issue   = (op == OP_READ) && (state inside {ST_M1, ST_M2, ST_M3, ST_M4, ST_M5});
    assign step_done  = is_rw(state) ? phase : 1'b1;
    assign last_addr  = is_down(state) ? (addr == '0) : (addr == ADDR_TOP);
    assign next_elem  = (elem_num(state) == 3'(NUM_ELEM - 1)) ? ST_DRAIN : state_e'(state + 3'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            addr      <= '0;
            phase     <= 1'b0;
            busy_q    <= 1'b0;
            bist_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bist_start) begin
                        state     <= ST_M0;
                        addr      <= '0;
                        phase     <= 1'b0;
                        busy_q    <= 1'b1;
                        bist_done <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_IDLE;
                    busy_q    <= 1'b0;
                    bist_done <= 1'b1;
                end
                default: begin
                    if (!step_done) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (last_addr) begin
                            state <= next_elem;
                            addr  <= is_down(next_elem) ? ADDR_TOP : '0;
                        end else begin
                            addr  <= is_down(state) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Tag each read so the compare a cycle later knows where it came from.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rd_elem <= '0;
            rd_addr <= '0;
        end else if (rd_issue) begin
            rd_elem <= elem_num(state);
            rd_addr <= addr;
        end
    end

    sram_bist_cmp u_cmp (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .q         ({sram_q7, sram_q6, sram_q5, sram_q4, sram_q3, sram_q2, sram_q1, sram_q0}),
        .expected  ({8{fill}}),
        .cmp_valid (rd_issue),
        .mismatch  (mismatch)
    );

    // Only the first mismatch is kept; later ones leave the capture alone.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            bist_fail  <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_lanes <= '0;
        end else if (state == ST_IDLE && bist_start) begin
            bist_fail  <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_lanes <= '0;
        end else if (|mismatch && !bist_fail) begin
            bist_fail  <= 1'b1;
            fail_addr  <= rd_addr;
            fail_elem  <= rd_elem;
            fail_lanes <= mismatch;
        end
    end

    assign bist_busy = busy_q;

    always_comb begin
        sram_w_en  = func_sram_w_en;
        bank0_csn  = func_bank0_csn;
        bank1_csn  = func_bank1_csn;
        sram_addr  = func_sram_addr;
        sram_wdata = func_sram_wdata;
        if (busy_q) begin
            sram_w_en  = logic'(op);
            bank0_csn  = 4'b0000;
            bank1_csn  = 4'b0000;
            sram_addr  = addr;
            sram_wdata = bist_wdata;
        end
    end

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: behavioural 8-lane SRAM with an injectable stuck-at bit,
// an abstract March C- reference model and a done-triggered scoreboard.
module tb_sram_bist;

    localparam int ADDR_W = 3;
    localparam int N      = 1 << ADDR_W;

    logic              hclk;
    logic              hresetn;
    logic              bist_start;
    logic              func_sram_w_en;
    logic [3:0]        func_bank0_csn;
    logic [3:0]        func_bank1_csn;
    logic [ADDR_W-1:0] func_sram_addr;
    logic [31:0]       func_sram_wdata;
    logic [7:0]        sram_q0, sram_q1, sram_q2, sram_q3;
    logic [7:0]        sram_q4, sram_q5, sram_q6, sram_q7;
    logic              sram_w_en;
    logic [3:0]        bank0_csn;
    logic [3:0]        bank1_csn;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic              bist_busy;
    logic              bist_done;
    logic              bist_fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [7:0]        fail_lanes;

    sram_bist #(.ADDR_W(ADDR_W)) dut (
        .hclk            (hclk),
        .hresetn         (hresetn),
        .bist_start      (bist_start),
        .func_sram_w_en  (func_sram_w_en),
        .func_bank0_csn  (func_bank0_csn),
        .func_bank1_csn  (func_bank1_csn),
        .func_sram_addr  (func_sram_addr),
        .func_sram_wdata (func_sram_wdata),
        .sram_q0         (sram_q0),
        .sram_q1         (sram_q1),
        .sram_q2         (sram_q2),
        .sram_q3         (sram_q3),
        .sram_q4         (sram_q4),
        .sram_q5         (sram_q5),
        .sram_q6         (sram_q6),
        .sram_q7         (sram_q7),
        .sram_w_en       (sram_w_en),
        .bank0_csn       (bank0_csn),
        .bank1_csn       (bank1_csn),
        .sram_addr       (sram_addr),
        .sram_wdata      (sram_wdata),
        .bist_busy       (bist_busy),
        .bist_done       (bist_done),
        .bist_fail       (bist_fail),
        .fail_addr       (fail_addr),
        .fail_elem       (fail_elem),
        .fail_lanes      (fail_lanes)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Fault: one lane at one address reads with the masked bits stuck at a value.
    bit         flt_en;
    int         flt_addr;
    int         flt_lane;
    logic [7:0] flt_mask;
    bit         flt_stuck;

    function automatic logic [7:0] apply_fault(input bit en, input int fa, input int fl,
                                               input logic [7:0] m, input bit st,
                                               input int a, input int l, input logic [7:0] v);
        if (en && a == fa && l == fl) return st ? (v | m) : (v & ~m);
        return v;
    endfunction

    // Behavioural SRAM: two banks of four byte lanes, registered read data.
    logic [7:0] mem [8][N];
    logic [7:0] q_r [8];
    logic [7:0] csn_all;

    assign csn_all = {bank1_csn, bank0_csn};
    assign {sram_q7, sram_q6, sram_q5, sram_q4} = {q_r[7], q_r[6], q_r[5], q_r[4]};
    assign {sram_q3, sram_q2, sram_q1, sram_q0} = {q_r[3], q_r[2], q_r[1], q_r[0]};

    initial begin
        for (int l = 0; l < 8; l++) begin
            q_r[l] = '0;
            for (int a = 0; a < N; a++) mem[l][a] = '0;
        end
    end

    always @(posedge hclk) begin
        for (int l = 0; l < 8; l++) begin
            q_r[l] <= apply_fault(flt_en, flt_addr, flt_lane, flt_mask, flt_stuck,
                                  int'(sram_addr), l, mem[l][sram_addr]);
            if (!sram_w_en && !csn_all[l]) mem[l][sram_addr] <= sram_wdata[8*(l%4) +: 8];
        end
    end

    typedef struct {
        logic              fail;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        elem;
        logic [7:0]        lanes;
        int                ops;
        int                done_cyc;
    } exp_t;

    exp_t sb_q[$];

    // March C- applied to an array of bytes; reports first mismatch and op count.
    function automatic exp_t model_march(input bit en, input int fa, input int fl,
                                         input logic [7:0] m, input bit st);
        exp_t       r;
        logic [7:0] arr [8][N];
        logic [7:0] want;
        logic [7:0] wv;
        logic [7:0] lanes;
        int         a;
        bit         dn;
        r = '{default: 0};
        for (int e = 0; e < 6; e++) begin
            dn = (e == 3 || e == 4);
            for (int k = 0; k < N; k++) begin
                a = dn ? (N - 1 - k) : k;
                if (e > 0) begin
                    want  = (e == 2 || e == 4) ? 8'hFF : 8'h00;
                    lanes = '0;
                    for (int l = 0; l < 8; l++)
                        if (apply_fault(en, fa, fl, m, st, a, l, arr[l][a]) != want) lanes[l] = 1'b1;
                    r.ops++;
                    if (lanes != 0 && !r.fail) begin
                        r.fail  = 1'b1;
                        r.addr  = a[ADDR_W-1:0];
                        r.elem  = e[2:0];
                        r.lanes = lanes;
                    end
                end
                if (e < 5) begin
                    wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
                    for (int l = 0; l < 8; l++) arr[l][a] = wv;
                    r.ops++;
                end
            end
        end
        return r;
    endfunction

    // Monitor: each completed test pops one expectation.
    logic done_prev = 1'b0;
    exp_t mon_exp;

    always @(negedge hclk) begin
        if (hresetn && bist_done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(bist_done), 64'(0));
            end else begin
                mon_exp = sb_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(mon_exp.done_cyc));
                check("bist_fail", 64'(bist_fail), 64'(mon_exp.fail));
                check("fail_addr", 64'(fail_addr), 64'(mon_exp.addr));
                check("fail_elem", 64'(fail_elem), 64'(mon_exp.elem));
                check("fail_lanes", 64'(fail_lanes), 64'(mon_exp.lanes));
            end
        end
        done_prev <= bist_done;
    end

    task automatic rand_func();
        func_sram_w_en  = 1'($urandom);
        func_bank0_csn  = 4'($urandom);
        func_bank1_csn  = 4'($urandom);
        func_sram_addr  = ADDR_W'($urandom);
        func_sram_wdata = $urandom;
    endtask

    task automatic check_mux(input string tag);
        check({tag, "_w_en"}, 64'(sram_w_en), 64'(func_sram_w_en));
        check({tag, "_b0csn"}, 64'(bank0_csn), 64'(func_bank0_csn));
        check({tag, "_b1csn"}, 64'(bank1_csn), 64'(func_bank1_csn));
        check({tag, "_addr"}, 64'(sram_addr), 64'(func_sram_addr));
        check({tag, "_wdata"}, 64'(sram_wdata), 64'(func_sram_wdata));
    endtask

    task automatic check_status_clear(input string tag);
        check({tag, "_done"}, 64'(bist_done), 64'(0));
        check({tag, "_fail"}, 64'(bist_fail), 64'(0));
        check({tag, "_faddr"}, 64'(fail_addr), 64'(0));
        check({tag, "_felem"}, 64'(fail_elem), 64'(0));
        check({tag, "_flanes"}, 64'(fail_lanes), 64'(0));
    endtask

    task automatic check_pass(input logic [ADDR_W-1:0] a, input logic [3:0] c0,
                              input logic [3:0] c1, input logic w, input logic [31:0] d);
        @(negedge hclk);
        func_sram_addr  = a;
        func_bank0_csn  = c0;
        func_bank1_csn  = c1;
        func_sram_w_en  = w;
        func_sram_wdata = d;
        #1;
        check("idle_busy", 64'(bist_busy), 64'(0));
        check_mux("pass");
    endtask

    task automatic run_test(input bit en, input int fa, input int fl, input logic [7:0] m,
                            input bit st, input int repulse_at, input int reset_at);
        exp_t x;
        flt_en    = en;
        flt_addr  = fa;
        flt_lane  = fl;
        flt_mask  = m;
        flt_stuck = st;
        x = model_march(en, fa, fl, m, st);
        @(negedge hclk);
        bist_start = 1'b1;
        x.done_cyc = cyc + 1 + x.ops + 1;
        if (reset_at < 0) sb_q.push_back(x);
        @(negedge hclk);
        bist_start = 1'b0;
        check("start_busy", 64'(bist_busy), 64'(1));
        check_status_clear("start");
        check("first_w_en", 64'(sram_w_en), 64'(0));
        check("first_addr", 64'(sram_addr), 64'(0));
        check("first_wdata", 64'(sram_wdata), 64'(0));
        for (int i = 1; i < 300; i++) begin
            if (!bist_busy) break;
            check("busy_csn", 64'(csn_all), 64'(0));
            rand_func();
            bist_start = (i == repulse_at);
            if (i == reset_at) begin
                bist_start = 1'b0;
                #2 hresetn = 1'b0;
                #1;
                check("rst_busy", 64'(bist_busy), 64'(0));
                check_status_clear("rst");
                check_mux("rst");
                repeat (2) @(negedge hclk);
                hresetn = 1'b1;
                break;
            end
            @(negedge hclk);
        end
        bist_start = 1'b0;
        if (reset_at < 0) begin
            check("end_done", 64'(bist_done), 64'(1));
            check("end_busy", 64'(bist_busy), 64'(0));
        end
    endtask

    initial begin
        hresetn    = 1'b0;
        bist_start = 1'b0;
        flt_en     = 1'b0;
        flt_addr   = 0;
        flt_lane   = 0;
        flt_mask   = '0;
        flt_stuck  = 1'b0;
        rand_func();
        repeat (3) @(negedge hclk);
        #1;
        check("reset_busy", 64'(bist_busy), 64'(0));
        check_status_clear("reset");
        check_mux("reset");
        @(negedge hclk);
        hresetn = 1'b1;

        run_test(1'b0, 0, 0, 8'h00, 1'b0, -1, -1);
        run_test(1'b1, 3, 6, 8'h20, 1'b1, -1, -1);
        check_pass(ADDR_W'(13'h1A5), 4'b1100, 4'b1111, 1'b0, 32'hDEADBEEF);
        check("fail_sticky", 64'(bist_fail), 64'(1));
        run_test(1'b1, 5, 4, 8'hFF, 1'b0, -1, -1);
        run_test(1'b0, 0, 0, 8'h00, 1'b0, 30, -1);
        run_test(1'b0, 0, 0, 8'h00, 1'b0, -1, 20);
        run_test(1'b0, 0, 0, 8'h00, 1'b0, -1, -1);

        for (int t = 0; t < 6; t++) begin
            run_test(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                     int'($urandom_range(0, 7)), 8'(1 << $urandom_range(0, 7)),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 60)) : -1, -1);
            check_pass(ADDR_W'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), $urandom);
        end

        repeat (3) @(negedge hclk);
        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
